// File: rtl/difftest_archreg_snapshot_sched_if.sv
// Request and stream signals of the difftest architectural-register snapshot scheduler.
// The slave modport is the scheduler; the master modport is the cores plus the difftest sink.
interface difftest_archreg_snapshot_sched_if #(
  parameter int NUM_CORES     = 2,
  parameter int REGS_PER_BEAT = 4
);
  localparam int SNAP_W = 32 * 64;
  localparam int BEAT_W = REGS_PER_BEAT * 64;
  localparam int BEATS  = 32 / REGS_PER_BEAT;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [NUM_CORES-1:0]        req_valid;
  logic [NUM_CORES-1:0]        req_ready;
  logic [NUM_CORES*SNAP_W-1:0] req_value;
  logic                        out_valid;
  logic                        out_ready;
  logic [BEAT_W-1:0]           out_data;
  logic [IDX_W-1:0]            out_index;
  logic [7:0]                  out_coreid;
  logic                        out_last;
  logic                        busy;

  modport master (
    output req_valid, req_value, out_ready,
    input  req_ready, out_valid, out_data, out_index, out_coreid, out_last, busy
  );

  modport slave (
    input  req_valid, req_value, out_ready,
    output req_ready, out_valid, out_data, out_index, out_coreid, out_last, busy
  );
endinterface

// File: rtl/difftest_archreg_snapshot_sched.sv
// Round-robin capture of one core's 32 x 64-bit register snapshot, streamed to the
// difftest sink as 32/REGS_PER_BEAT beats tagged with the core id.
module difftest_archreg_snapshot_sched #(
  parameter int         NUM_CORES     = 2,
  parameter int         REGS_PER_BEAT = 4,
  parameter logic [7:0] CORE_ID_BASE  = 8'd0
) (
  input logic                              clock,
  input logic                              reset_n,
  difftest_archreg_snapshot_sched_if.slave bus
);
  localparam int SNAP_W = 32 * 64;
  localparam int BEAT_W = REGS_PER_BEAT * 64;
  localparam int BEATS  = 32 / REGS_PER_BEAT;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   next_ptr;
  logic               found;
  int                 cand;
  logic [SNAP_W-1:0]  win_value;
  logic [SNAP_W-1:0]  buffer;
  logic [IDX_W-1:0]   beat;
  logic [IDX_W-1:0]   next_beat;
  logic               capture;
  logic               retire;
  logic               last_retire;
  logic [BEAT_W-1:0]  data_q;
  logic [7:0]         coreid_q;
  logic               last_q;

  // Scan offsets from far to near so the requester closest to rr_ptr is written last and wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : arbiter
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int off = NUM_CORES - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % NUM_CORES;
      if (bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = PTR_W'(cand);
      end
    end
  end

  assign win_value   = bus.req_value[int'(winner)*SNAP_W +: SNAP_W];
  assign next_ptr    = PTR_W'((int'(winner) + 1) % NUM_CORES);
  assign capture     = (state == IDLE) && found;
  assign retire      = (state == STREAM) && bus.out_ready;
  assign last_retire = retire && (int'(beat) == BEATS - 1);
  assign next_beat   = beat + IDX_W'(1);

  always_comb begin : fsm_next
    next_state = state;
    unique case (state)
      IDLE:    if (capture)     next_state = STREAM;
      STREAM:  if (last_retire) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin : fsm_state
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: the snapshot buffer is not reset; it is always written by a capture before being read.
  always_ff @(posedge clock) begin : snapshot_buffer
    if (capture) buffer <= win_value;
  end

  // Beat 0 is loaded straight from the winning request since the buffer fills on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin : stream_regs
    if (!reset_n) begin
      rr_ptr   <= '0;
      beat     <= '0;
      data_q   <= '0;
      coreid_q <= '0;
      last_q   <= 1'b0;
    end else if (capture) begin
      rr_ptr   <= next_ptr;
      beat     <= '0;
      data_q   <= win_value[BEAT_W-1:0];
      coreid_q <= CORE_ID_BASE + 8'(winner);
      last_q   <= (BEATS == 1);
    end else if (retire && !last_retire) begin
      beat     <= next_beat;
      data_q   <= buffer[int'(next_beat)*BEAT_W +: BEAT_W];
      last_q   <= (int'(next_beat) == BEATS - 1);
    end
  end

  assign bus.req_ready  = capture ? (NUM_CORES'(1) << winner) : '0;
  assign bus.out_valid  = (state == STREAM);
  assign bus.busy       = (state == STREAM);
  assign bus.out_data   = data_q;
  assign bus.out_index  = beat;
  assign bus.out_coreid = coreid_q;
  assign bus.out_last   = last_q;
endmodule

// File: tb/tb_difftest_archreg_snapshot_sched.sv
// Directed bench: single-core stream, backpressure with post-grant data change,
// two-core round robin, mid-stream reset and the single-beat configuration.
module tb_difftest_archreg_snapshot_sched;
  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  difftest_archreg_snapshot_sched_if #(.NUM_CORES(1), .REGS_PER_BEAT(4))  if_a ();
  difftest_archreg_snapshot_sched_if #(.NUM_CORES(2), .REGS_PER_BEAT(4))  if_b ();
  difftest_archreg_snapshot_sched_if #(.NUM_CORES(2), .REGS_PER_BEAT(32)) if_c ();

  difftest_archreg_snapshot_sched #(.NUM_CORES(1), .REGS_PER_BEAT(4), .CORE_ID_BASE(8'd0))
    dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
  difftest_archreg_snapshot_sched #(.NUM_CORES(2), .REGS_PER_BEAT(4), .CORE_ID_BASE(8'd4))
    dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));
  difftest_archreg_snapshot_sched #(.NUM_CORES(2), .REGS_PER_BEAT(32), .CORE_ID_BASE(8'd0))
    dut_c (.clock(clock), .reset_n(reset_n), .bus(if_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int exp_k;
    int stalls;

    reset_n        = 1'b1;
    if_a.req_valid = '0;
    if_a.req_value = '0;
    if_a.out_ready = 1'b1;
    if_b.req_valid = '0;
    if_b.req_value = '0;
    if_b.out_ready = 1'b1;
    if_c.req_valid = '0;
    if_c.req_value = '0;
    if_c.out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;

    // Reset state
    check("rst_a_valid",  if_a.out_valid, 0);
    check("rst_a_busy",   if_a.busy, 0);
    check("rst_a_ready",  if_a.req_ready, 0);
    check("rst_a_data",   if_a.out_data[63:0], 0);
    check("rst_a_last",   if_a.out_last, 0);
    check("rst_b_index",  if_b.out_index, 0);
    check("rst_b_coreid", if_b.out_coreid, 0);
    check("rst_c_valid",  if_c.out_valid, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // T1: single core, 8 beats of 4 regs
    for (int r = 0; r < 32; r++) if_a.req_value[r*64 +: 64] = 64'h1000 + 64'(r);
    @(negedge clock);
    if_a.req_valid = 1'b1;
    #1;
    check("t1_grant", if_a.req_ready, 1);
    check("t1_idle_busy", if_a.busy, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 1) if_a.req_valid = 1'b0;
      #1;
      check($sformatf("t1_valid_b%0d", k), if_a.out_valid, 1);
      check($sformatf("t1_index_b%0d", k), if_a.out_index, 64'(k));
      check($sformatf("t1_lo_b%0d", k), if_a.out_data[63:0], 64'h1000 + 64'(4*k));
      check($sformatf("t1_hi_b%0d", k), if_a.out_data[255:192], 64'h1000 + 64'(4*k + 3));
      check($sformatf("t1_last_b%0d", k), if_a.out_last, 64'(k == 7));
      check($sformatf("t1_noready_b%0d", k), if_a.req_ready, 0);
    end
    @(negedge clock);
    check("t1_done_valid", if_a.out_valid, 0);
    check("t1_done_busy", if_a.busy, 0);

    // T2 + T4: backpressure at beat 2, request data overwritten right after the grant
    for (int r = 0; r < 32; r++) if_a.req_value[r*64 +: 64] = 64'h2000 + 64'(r);
    if_a.req_valid = 1'b1;
    exp_k  = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        if_a.req_valid = 1'b0;
        for (int r = 0; r < 32; r++) if_a.req_value[r*64 +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(r);
      end
      #1;
      check($sformatf("t2_valid_c%0d", cyc), if_a.out_valid, 1);
      check($sformatf("t2_index_c%0d", cyc), if_a.out_index, 64'(exp_k));
      check($sformatf("t2_lo_c%0d", cyc), if_a.out_data[63:0], 64'h2000 + 64'(4*exp_k));
      check($sformatf("t2_hi_c%0d", cyc), if_a.out_data[255:192], 64'h2000 + 64'(4*exp_k + 3));
      check($sformatf("t2_last_c%0d", cyc), if_a.out_last, 64'(exp_k == 7));
      if (exp_k == 2 && stalls < 3) begin
        if_a.out_ready = 1'b0;
        stalls++;
      end else begin
        if_a.out_ready = 1'b1;
        exp_k++;
      end
    end
    @(negedge clock);
    check("t2_done_valid", if_a.out_valid, 0);

    // T3: two cores both pending, round robin 4,5,4,5 with a dead cycle between streams
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++)
        if_b.req_value[c*2048 + r*64 +: 64] = 64'hB000 + 64'(c*256 + r);
    if_b.req_valid = 2'b11;
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("t3_grant_s%0d", s), if_b.req_ready, (s % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t3_gap_s%0d", s), if_b.out_valid, 0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        #1;
        check($sformatf("t3_valid_s%0d_b%0d", s, k), if_b.out_valid, 1);
        check($sformatf("t3_coreid_s%0d_b%0d", s, k), if_b.out_coreid, 64'(4 + s % 2));
        check($sformatf("t3_index_s%0d_b%0d", s, k), if_b.out_index, 64'(k));
        check($sformatf("t3_lo_s%0d_b%0d", s, k), if_b.out_data[63:0],
              64'hB000 + 64'((s % 2)*256 + 4*k));
        check($sformatf("t3_noready_s%0d_b%0d", s, k), if_b.req_ready, 0);
      end
      @(negedge clock);
      if (s == 3) if_b.req_valid = 2'b00;
      #1;
    end
    @(negedge clock);
    check("t3_idle_after_drop", if_b.out_valid, 0);

    // T5: reset at beat 5 with rr_ptr pointing at core 1
    if_b.req_valid = 2'b01;
    #1;
    check("t5_grant0", if_b.req_ready, 2'b01);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 0) if_b.req_valid = 2'b00;
      #1;
      check($sformatf("t5_index_b%0d", k), if_b.out_index, 64'(k));
    end
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid",  if_b.out_valid, 0);
    check("t5_rst_busy",   if_b.busy, 0);
    check("t5_rst_index",  if_b.out_index, 0);
    check("t5_rst_coreid", if_b.out_coreid, 0);
    check("t5_rst_data",   if_b.out_data[63:0], 0);
    @(negedge clock);
    reset_n = 1'b1;
    if_b.req_valid = 2'b11;
    #1;
    check("t5_tie_grant", if_b.req_ready, 2'b01);
    @(negedge clock);
    if_b.req_valid = 2'b00;
    #1;
    check("t5_tie_valid",  if_b.out_valid, 1);
    check("t5_tie_coreid", if_b.out_coreid, 4);
    repeat (8) @(negedge clock);
    #1;
    check("t5_drained", if_b.out_valid, 0);

    // T6: one 32-register beat per snapshot
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++)
        if_c.req_value[c*2048 + r*64 +: 64] = 64'hC000 + 64'(c*256 + r);
    if_c.req_valid = 2'b10;
    #1;
    check("t6_grant1", if_c.req_ready, 2'b10);
    @(negedge clock);
    if_c.req_valid = 2'b00;
    #1;
    check("t6_valid1",  if_c.out_valid, 1);
    check("t6_index1",  if_c.out_index, 0);
    check("t6_last1",   if_c.out_last, 1);
    check("t6_coreid1", if_c.out_coreid, 1);
    check("t6_lo1",     if_c.out_data[63:0], 64'hC100);
    check("t6_hi1",     if_c.out_data[2047:1984], 64'hC11F);
    @(negedge clock);
    if_c.req_valid = 2'b01;
    #1;
    check("t6_done1",  if_c.out_valid, 0);
    check("t6_grant0", if_c.req_ready, 2'b01);
    @(negedge clock);
    if_c.req_valid = 2'b00;
    #1;
    check("t6_last0",   if_c.out_last, 1);
    check("t6_index0",  if_c.out_index, 0);
    check("t6_coreid0", if_c.out_coreid, 0);
    check("t6_hi0",     if_c.out_data[2047:1984], 64'hC01F);
    @(negedge clock);
    #1;
    check("t6_done0", if_c.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
